// File: rtl/shift_seq_if.sv
// rtl/shift_seq_if.sv - request/result bundle for the two-port shift sequencer
//
// Signals:
//   req0_*/req1_* : per-requester operation (vld, data[15:0], cnt[3:0], op[1:0]) and rdy
//   res_vld/res_data/res_id/res_rdy : result handshake toward the consumer
//   busy          : sequencer is not idle
// Modports:
//   master : requester/consumer side (drives requests and res_rdy)
//   slave  : the sequencer itself
interface shift_seq_if;
    logic        req0_vld;
    logic [15:0] req0_data;
    logic [3:0]  req0_cnt;
    logic [1:0]  req0_op;
    logic        req0_rdy;

    logic        req1_vld;
    logic [15:0] req1_data;
    logic [3:0]  req1_cnt;
    logic [1:0]  req1_op;
    logic        req1_rdy;

    logic        res_vld;
    logic [15:0] res_data;
    logic        res_id;
    logic        res_rdy;

    logic        busy;

    modport master (
        output req0_vld, req0_data, req0_cnt, req0_op,
        output req1_vld, req1_data, req1_cnt, req1_op,
        output res_rdy,
        input  req0_rdy, req1_rdy,
        input  res_vld, res_data, res_id,
        input  busy
    );

    modport slave (
        input  req0_vld, req0_data, req0_cnt, req0_op,
        input  req1_vld, req1_data, req1_cnt, req1_op,
        input  res_rdy,
        output req0_rdy, req1_rdy,
        output res_vld, res_data, res_id,
        output busy
    );
endinterface

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - two-requester round-robin 16-bit shift sequencer
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : shift_seq_if.slave (requests, result handshake, busy)
// Operations (op): 00 SLL, 01 SRL, 10 ROL, 11 SRA, shift amount cnt 0..15.
// Optional build macro: SHIFT_SEQ_FAST_EN - whole shift computed on accept,
// result valid one cycle after accept for every cnt; otherwise one bit per cycle.
module shift_seq (
    input  logic        clk,
    input  logic        rst_n,
    shift_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        last_q;     // requester granted most recently
    logic        grant;      // requester offered rdy while idle
    logic [15:0] work_q;     // operand being shifted in SHIFT
    logic [3:0]  rem_q;      // steps still to apply
    logic [1:0]  op_q;
    logic        id_q;
    logic [15:0] res_data_q;
    logic        res_id_q;

    logic        accept;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;

    // One 1-bit step of the selected operation.
    function automatic logic [15:0] step(input logic [15:0] d, input logic [1:0] op);
        logic [15:0] r;
        case (op)
            2'b00:   r = {d[14:0], 1'b0};
            2'b01:   r = {1'b0, d[15:1]};
            2'b10:   r = {d[14:0], d[15]};
            default: r = {d[15], d[15:1]};
        endcase
        return r;
    endfunction

`ifdef SHIFT_SEQ_FAST_EN
    // Full cnt-bit shift in one pass; rotate takes the upper half of a
    // doubled word so cnt==0 needs no special case.
    function automatic logic [15:0] full_shift(input logic [15:0] d, input logic [1:0] op,
                                               input logic [3:0] c);
        logic [31:0] dd;
        logic [15:0] r;
        dd = {d, d} << c;
        case (op)
            2'b00:   r = d << c;
            2'b01:   r = d >> c;
            2'b10:   r = dd[31:16];
            default: r = 16'($signed(d) >>> c);
        endcase
        return r;
    endfunction
`endif

    // Round-robin: a sole requester wins, a tie goes to the one not served last.
    // With no requester the pointer choice is harmless since nothing transfers.
    always_comb begin
        grant = ~last_q;
        if (bus.req0_vld && !bus.req1_vld) begin
            grant = 1'b0;
        end else if (bus.req1_vld && !bus.req0_vld) begin
            grant = 1'b1;
        end
    end

    assign bus.req0_rdy = (state_q == IDLE) && (grant == 1'b0);
    assign bus.req1_rdy = (state_q == IDLE) && (grant == 1'b1);

    assign accept  = (bus.req0_vld && bus.req0_rdy) || (bus.req1_vld && bus.req1_rdy);
    assign in_data = grant ? bus.req1_data : bus.req0_data;
    assign in_cnt  = grant ? bus.req1_cnt  : bus.req0_cnt;
    assign in_op   = grant ? bus.req1_op   : bus.req0_op;

    assign bus.res_vld  = (state_q == DONE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.res_data = res_data_q;
    assign bus.res_id   = res_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef SHIFT_SEQ_FAST_EN
                    state_d = DONE;
`else
                    state_d = (in_cnt == 4'd0) ? DONE : SHIFT;
`endif
                end
            end
            SHIFT: begin
                // The final step lands in the same edge that enters DONE.
                if (rem_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            work_q     <= 16'h0000;
            rem_q      <= 4'd0;
            op_q       <= 2'b00;
            id_q       <= 1'b0;
            res_data_q <= 16'h0000;
            res_id_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_q <= grant;
                        id_q   <= grant;
                        op_q   <= in_op;
                        work_q <= in_data;
`ifdef SHIFT_SEQ_FAST_EN
                        rem_q      <= 4'd0;
                        res_data_q <= full_shift(in_data, in_op, in_cnt);
                        res_id_q   <= grant;
`else
                        rem_q <= in_cnt;
                        if (in_cnt == 4'd0) begin
                            res_data_q <= in_data;
                            res_id_q   <= grant;
                        end
`endif
                    end
                end
                SHIFT: begin
                    work_q <= step(work_q, op_q);
                    rem_q  <= rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        res_data_q <= step(work_q, op_q);
                        res_id_q   <= id_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - self-checking bench for shift_seq
module tb_shift_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic last_tb;

    shift_seq_if bus ();

    shift_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: shift by c expressed as multiply/divide by 2**c.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] op, input int c);
        int v;
        int p;
        int r;
        v = int'(d);
        p = 1 << c;
        case (op)
            2'd0:    r = (v * p) % 65536;
            2'd1:    r = v / p;
            2'd2:    r = ((v * p) % 65536) + ((v * p) / 65536);
            default: r = (v >= 32768) ? (v / p + 65536 - 65536 / p) : (v / p);
        endcase
        return 16'(r);
    endfunction

    function automatic int exp_lat(input int c);
`ifdef SHIFT_SEQ_FAST_EN
        return 1 + 0 * c;
`else
        return c + 1;
`endif
    endfunction

    function automatic logic rdy_of(input logic p);
        return p ? bus.req1_rdy : bus.req0_rdy;
    endfunction

    task automatic present(input logic p, input logic [1:0] op, input logic [15:0] d,
                           input logic [3:0] c);
        if (p) begin
            bus.req1_vld = 1'b1; bus.req1_op = op; bus.req1_data = d; bus.req1_cnt = c;
        end else begin
            bus.req0_vld = 1'b1; bus.req0_op = op; bus.req0_data = d; bus.req0_cnt = c;
        end
    endtask

    // Waits (bounded) until port p is offered rdy, then checks exclusivity.
    task automatic wait_rdy(input logic p);
        int n;
        n = 0;
        #1;
        while (rdy_of(p) !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rdy_timeout", 32'(n < 50), 32'd1);
        check("rdy_exclusive", 32'(rdy_of(!p)), 32'd0);
    endtask

    // Called just after the accept edge.
    task automatic wait_result(input logic [15:0] ed, input logic eid, input int elat, input int hold);
        int   lat;
        logic stable;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.res_vld !== 1'b1 && lat < 40);
        check("latency", 32'(lat), 32'(elat));
        check("res_data", 32'(bus.res_data), 32'(ed));
        check("res_id", 32'(bus.res_id), 32'(eid));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.res_vld !== 1'b1 || bus.res_data !== ed || bus.res_id !== eid ||
                bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", 32'(stable), 32'd1);
        bus.res_rdy = 1'b1;
        @(negedge clk);
        bus.res_rdy = 1'b0;
        check("idle_after_release", 32'({bus.busy, bus.res_vld}), 32'd0);
        check("res_data_held", 32'(bus.res_data), 32'(ed));
    endtask

    task automatic run_op(input logic p, input logic [1:0] op, input logic [15:0] d,
                          input logic [3:0] c, input int hold);
        @(negedge clk);
        present(p, op, d, c);
        wait_rdy(p);
        @(posedge clk);
        #1;
        bus.req0_vld = 1'b0;
        bus.req1_vld = 1'b0;
        last_tb = p;
        wait_result(model(d, op, int'(c)), p, exp_lat(int'(c)), hold);
    endtask

    initial begin
        logic        both;
        logic        win;
        logic [1:0]  op0, op1;
        logic [15:0] d0, d1;
        logic [3:0]  c0, c1;
        logic        saw_vld;

        checks = 0;
        errors = 0;
        last_tb = 1'b1;
        bus.req0_vld = 0; bus.req0_data = 0; bus.req0_cnt = 0; bus.req0_op = 0;
        bus.req1_vld = 0; bus.req1_data = 0; bus.req1_cnt = 0; bus.req1_op = 0;
        bus.res_rdy = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_res_vld", 32'(bus.res_vld), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
        rst_n = 1'b1;

        // Tie right after reset: port 0 first, port 1 waits, then port 0 wins next tie.
        present(1'b0, 2'b00, 16'h00F0, 4'd2);
        present(1'b1, 2'b01, 16'h0F00, 4'd3);
        wait_rdy(1'b0);
        @(posedge clk);
        #1;
        bus.req0_vld = 1'b0;
        wait_result(model(16'h00F0, 2'b00, 2), 1'b0, exp_lat(2), 2);
        #1;
        check("pending_req1_rdy", 32'(bus.req1_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.req1_vld = 1'b0;
        wait_result(model(16'h0F00, 2'b01, 3), 1'b1, exp_lat(3), 0);
        present(1'b0, 2'b11, 16'h8000, 4'd4);
        present(1'b1, 2'b10, 16'h1234, 4'd5);
        wait_rdy(1'b0);
        @(posedge clk);
        #1;
        bus.req0_vld = 1'b0;
        bus.req1_vld = 1'b0;
        check("sra_example", 32'(model(16'h8000, 2'b11, 4)), 32'h0000F800);
        wait_result(16'hF800, 1'b0, exp_lat(4), 0);
        last_tb = 1'b0;

        // Directed corner cases.
        run_op(1'b1, 2'b10, 16'h8001, 4'd1, 0);
        run_op(1'b1, 2'b01, 16'h8001, 4'd15, 0);
        run_op(1'b0, 2'b00, 16'h1234, 4'd0, 0);
        run_op(1'b1, 2'b11, 16'h7FFF, 4'd15, 5);
        run_op(1'b0, 2'b10, 16'hA5C3, 4'd15, 5);

        // Randomized traffic with occasional ties.
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            both = ($urandom % 3) == 0;
            op0 = 2'($urandom); d0 = 16'($urandom); c0 = 4'($urandom);
            op1 = 2'($urandom); d1 = 16'($urandom); c1 = 4'($urandom);
            if (both) begin
                win = !last_tb;
                present(1'b0, op0, d0, c0);
                present(1'b1, op1, d1, c1);
            end else begin
                win = 1'($urandom);
                if (win) present(1'b1, op1, d1, c1);
                else     present(1'b0, op0, d0, c0);
            end
            wait_rdy(win);
            @(posedge clk);
            #1;
            bus.req0_vld = 1'b0;
            bus.req1_vld = 1'b0;
            last_tb = win;
            if (win) wait_result(model(d1, op1, int'(c1)), 1'b1, exp_lat(int'(c1)), int'($urandom_range(0, 2)));
            else     wait_result(model(d0, op0, int'(c0)), 1'b0, exp_lat(int'(c0)), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a long shift.
        @(negedge clk);
        present(1'b1, 2'b00, 16'h0001, 4'd8);
        wait_rdy(1'b1);
        @(posedge clk);
        #1;
        bus.req1_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_res_vld", 32'(bus.res_vld), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_res_data", 32'(bus.res_data), 32'd0);
        check("midrst_res_id", 32'(bus.res_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_tb = 1'b1;
        saw_vld = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.res_vld !== 1'b0) saw_vld = 1'b1;
        end
        check("no_result_after_reset", 32'(saw_vld), 32'd0);

        // Pointer restored by reset: port 0 wins a tie again.
        present(1'b0, 2'b01, 16'hFFFF, 4'd4);
        present(1'b1, 2'b00, 16'hFFFF, 4'd4);
        wait_rdy(1'b0);
        @(posedge clk);
        #1;
        bus.req0_vld = 1'b0;
        bus.req1_vld = 1'b0;
        wait_result(16'h0FFF, 1'b0, exp_lat(4), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports req0_vld and req1_vld, input, 1 bit each: requester N presents an operation.
REQ-004 SHALL have ports req0_data and req1_data, input, 16 bits each: operand for requester N.
REQ-005 SHALL have ports req0_cnt and req1_cnt, input, 4 bits each: shift amount 0-15.
REQ-006 SHALL have ports req0_op and req1_op, input, 2 bits each: 00 SLL, 01 SRL, 10 ROL, 11 SRA.
REQ-007 SHALL have ports req0_rdy and req1_rdy, output, 1 bit each: controller accepts requester N this cycle.
REQ-008 SHALL have port res_vld, output, 1 bit: result valid.
REQ-009 SHALL have port res_data, output, 16 bits: shifted result.
REQ-010 SHALL have port res_id, output, 1 bit: index of the requester that owns res_data.
REQ-011 SHALL have port res_rdy, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE.
REQ-014 SHALL use round-robin arbitration: in IDLE, grant is the sole valid requester; if both are valid, grant goes to the requester not granted last.
REQ-015 SHALL drive reqN_rdy = (state==IDLE) && grant==N, and SHALL NOT drive req0_rdy and req1_rdy high together.
REQ-016 SHALL transfer a request when reqN_vld && reqN_rdy, registering data, cnt, op, id and the last-granted pointer.
REQ-017 SHALL move on accept with cnt!=0 to SHIFT, and on accept with cnt==0 to DONE with data unchanged.
REQ-018 SHALL, in SHIFT, apply exactly one 1-bit step of the registered op per cycle and decrement the remaining count.
REQ-019 SHALL define the 1-bit steps: SLL fills 0 at bit 0; SRL fills 0 at bit 15; ROL moves bit 15 to bit 0; SRA replicates bit 15.
REQ-020 SHALL enter DONE on the cycle the last step is applied, giving res_vld high exactly cnt+1 cycles after the accept edge.
REQ-021 SHALL, in DONE, hold res_vld=1 with res_data and res_id stable until res_rdy=1, then return to IDLE.
REQ-022 SHALL keep requests that arrive while busy waiting with rdy low, and SHALL NOT drop them.
REQ-023 SHALL keep res_vld=0 outside DONE, and SHALL keep res_data and res_id holding their last values.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force state IDLE, res_vld=0, res_data=0x0000, res_id=0, busy=0, remaining count 0, and the last-granted pointer set to 1 so that port 0 wins the first tie.
REQ-025 SHALL abandon any operation in progress when reset is asserted mid-SHIFT or mid-DONE, producing no result after reset releases.

Configuration
REQ-026 SHALL, with macro SHIFT_SEQ_FAST_EN defined, compute the full cnt-bit shift in one cycle on accept and go directly to DONE, giving res_vld at accept+1 for every cnt.
REQ-027 SHALL, without SHIFT_SEQ_FAST_EN, use the iterative behaviour of REQ-017 to REQ-020; results SHALL be identical in both builds.

Verification
REQ-028 SHALL cover: req0 op=11 data=0x8000 cnt=4 -> res_data=0xF800, res_id=0, res_vld at accept+5 (accept+1 with fast build).
REQ-029 SHALL cover: req1 op=10 data=0x8001 cnt=1 -> res_data=0x0003, res_id=1; and op=01 data=0x8001 cnt=15 -> 0x0001.
REQ-030 SHALL cover: both valid in the first cycle after reset, res_rdy=1 -> port 0 served first, then port 1, then port 0 on the next tie.
REQ-031 SHALL cover: cnt=0, op=00, data=0x1234 -> res_data=0x1234 at accept+1.
REQ-032 SHALL cover: res_rdy held low 5 cycles in DONE -> res_vld, res_data and res_id stable, both rdy low; release -> IDLE the next cycle.
REQ-033 SHALL cover: rst_n asserted mid-SHIFT with cnt=8 -> outputs reach reset values immediately, and no res_vld after release.
